// File: rtl/phy_rx_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the RGMII receive path: parser FSM states, framing
// bytes and the reflected CRC-32 constants used by both RX check and TX FCS.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int          FCS_BYTES     = 4;

endpackage

// File: rtl/phy_crc32_d8.sv
`timescale 1ns/1ps
// Combinational CRC-32 (reflected 0xEDB88320, LSB first) advanced by one byte.
// Shared between the RX FCS checker and the TX FCS generator.
module phy_crc32_d8
  import phy_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_step;

  // NOTE: blocking assignments chain the eight bit steps within one evaluation;
  // synthesis flattens the loop into a shallow XOR network.
  always_comb begin
    crc_step = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_step[0] ^ data[i]) begin
        crc_step = (crc_step >> 1) ^ CRC_POLY;
      end else begin
        crc_step = crc_step >> 1;
      end
    end
    crc_out = crc_step;
  end

endmodule

// File: rtl/phy_rx_frame_parser.sv
`timescale 1ns/1ps
// Receive frame parser: strips preamble/SFD, checks and removes the FCS, and
// streams the payload as AXI-Stream with a per-frame error flag and statistics.
module phy_rx_frame_parser
  import phy_rx_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             phy_rx_clk,
  input  logic             sys_rst,
  input  logic [7:0]       phy_rxd_in,
  input  logic             phy_rvalid_in,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] frame_good_cnt,
  output logic [CNT_W-1:0] frame_bad_cnt
);

  localparam int             LEN_W     = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
  localparam logic [2:0]     FILL_FULL = 3'(FCS_BYTES);

  rx_state_t        state;
  rx_state_t        state_nxt;

  logic [31:0]      crc;
  logic [31:0]      crc_upd;
  logic [LEN_W-1:0] byte_cnt;
  logic             at_max;

  logic [3:0][7:0]  dly;
  logic [2:0]       dly_fill;
  logic [7:0]       hold;
  logic             hold_full;

  logic             sof;
  logic             shift;
  logic             eof;
  logic             frame_bad;
  logic             emit;
  logic             emit_last;
  logic             emit_user;
  logic             good_inc;
  logic             bad_inc;

  phy_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (phy_rxd_in),
    .crc_out (crc_upd)
  );

  // The byte being sampled now is the one that takes the count to MAX_FRAME+1.
  assign at_max = (byte_cnt == LEN_MAX);

  always_ff @(posedge phy_rx_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (phy_rvalid_in) begin
          if (phy_rxd_in == PREAMBLE_BYTE) begin
            state_nxt = ST_PREAMBLE;
          end else if (phy_rxd_in == SFD_BYTE) begin
            state_nxt = ST_PAYLOAD;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!phy_rvalid_in) begin
          state_nxt = ST_IDLE;
        end else if (phy_rxd_in == SFD_BYTE) begin
          state_nxt = ST_PAYLOAD;
        end else if (phy_rxd_in != PREAMBLE_BYTE) begin
          state_nxt = ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (!phy_rvalid_in) begin
          state_nxt = ST_IDLE;
        end else if (at_max) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!phy_rvalid_in) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sof       = 1'b0;
    shift     = 1'b0;
    eof       = 1'b0;
    frame_bad = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_user = 1'b0;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    case (state)
      ST_IDLE, ST_PREAMBLE: begin
        sof = phy_rvalid_in && (phy_rxd_in == SFD_BYTE);
      end
      ST_PAYLOAD: begin
        if (phy_rvalid_in) begin
          shift = 1'b1;
          // Hold is overwritten only once the delay line is full.
          if ((dly_fill == FILL_FULL) && hold_full) begin
            emit      = 1'b1;
            emit_last = at_max;
            emit_user = at_max;
          end
          bad_inc = at_max;
        end else begin
          eof       = 1'b1;
          frame_bad = (crc != CRC_RESIDUE) || (byte_cnt < LEN_MIN);
          emit      = hold_full;
          emit_last = hold_full;
          emit_user = hold_full && frame_bad;
          good_inc  = hold_full && !frame_bad;
          bad_inc   = !hold_full || frame_bad;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the byte storage carries no reset; dly_fill and hold_full alone
  // decide which bytes are live, and both are cleared on reset.
  always_ff @(posedge phy_rx_clk) begin
    if (shift) begin
      dly <= {dly[2:0], phy_rxd_in};
      if (dly_fill == FILL_FULL) begin
        hold <= dly[3];
      end
    end
  end

  always_ff @(posedge phy_rx_clk) begin
    if (sys_rst) begin
      crc       <= CRC_INIT;
      byte_cnt  <= '0;
      dly_fill  <= '0;
      hold_full <= 1'b0;
    end else if (sof) begin
      crc       <= CRC_INIT;
      byte_cnt  <= '0;
      dly_fill  <= '0;
      hold_full <= 1'b0;
    end else if (shift) begin
      crc <= crc_upd;
      if (byte_cnt != LEN_SAT) begin
        byte_cnt <= byte_cnt + LEN_W'(1);
      end
      if (dly_fill != FILL_FULL) begin
        dly_fill <= dly_fill + 3'd1;
      end else begin
        hold_full <= 1'b1;
      end
    end else if (eof) begin
      dly_fill  <= '0;
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge phy_rx_clk) begin
    if (sys_rst) begin
      m_axis_tdata   <= 8'h00;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      frame_good_cnt <= '0;
      frame_bad_cnt  <= '0;
    end else begin
      m_axis_tvalid <= emit;
      m_axis_tlast  <= emit && emit_last;
      m_axis_tuser  <= emit && emit_user;
      if (emit) begin
        m_axis_tdata <= hold;
      end
      if (good_inc) begin
        frame_good_cnt <= frame_good_cnt + CNT_W'(1);
      end
      if (bad_inc) begin
        frame_bad_cnt <= frame_bad_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_frame_parser.sv
`timescale 1ns/1ps
// Scoreboard bench for phy_rx_frame_parser: stimulus pushes expected beats,
// a negedge monitor pops and compares every beat the parser presents.
module tb_phy_rx_frame_parser;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;
  localparam int CNT_W     = 16;

  logic             phy_rx_clk = 1'b0;
  logic             sys_rst;
  logic [7:0]       phy_rxd_in;
  logic             phy_rvalid_in;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic [CNT_W-1:0] frame_good_cnt;
  logic [CNT_W-1:0] frame_bad_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      sb_q[$];
  beat_t      mon_exp;
  logic [7:0] frame_q[$];
  int         n_pass  = 0;
  int         n_total = 0;

  always #4 phy_rx_clk = ~phy_rx_clk;

  phy_rx_frame_parser #(
    .MIN_FRAME (MIN_FRAME),
    .MAX_FRAME (MAX_FRAME),
    .CNT_W     (CNT_W)
  ) dut (
    .phy_rx_clk     (phy_rx_clk),
    .sys_rst        (sys_rst),
    .phy_rxd_in     (phy_rxd_in),
    .phy_rvalid_in  (phy_rvalid_in),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frame_good_cnt (frame_good_cnt),
    .frame_bad_cnt  (frame_bad_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge phy_rx_clk) begin
    if (m_axis_tvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: actual data 0x%02h last %0d user %0d, required no beat",
                 m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end else begin
        mon_exp = sb_q.pop_front();
        check("beat {data,last,user}", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
              32'(mon_exp));
      end
    end
  end

  task automatic put(input logic v, input logic [7:0] b);
    phy_rvalid_in = v;
    phy_rxd_in    = b;
    @(posedge phy_rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
  endtask

  task automatic build_frame(input int n, input bit flip_fcs);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(i));
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame_q[i]};
      repeat (8) c = (c >> 1) ^ (32'hEDB8_8320 & {32{c[0]}});
    end
    c = ~c;
    if (flip_fcs) c[0] = ~c[0];
    for (int j = 0; j < 4; j++) frame_q.push_back(c[8*j +: 8]);
  endtask

  task automatic expect_beats(input int n, input logic user, input bit with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = frame_q[i];
      b.last = with_last && (i == n - 1);
      b.user = with_last && (i == n - 1) && user;
      sb_q.push_back(b);
    end
  endtask

  task automatic send(input int pre, input int gap);
    int len;
    len = frame_q.size();
    repeat (pre) put(1'b1, 8'h55);
    put(1'b1, 8'hD5);
    for (int i = 0; i < len; i++) begin
      put(1'b1, frame_q[i]);
      if (i == 5) check("first_beat_latency tvalid", 32'(m_axis_tvalid), 32'd1);
    end
    put(1'b0, 8'h00);
    check("eof {tvalid,tlast}", 32'({m_axis_tvalid, m_axis_tlast}),
          (len >= 5 && len <= MAX_FRAME) ? 32'd3 : 32'd0);
    idle(gap - 1);
  endtask

  task automatic check_counts(input int good, input int bad);
    check("frame_good_cnt", 32'(frame_good_cnt), 32'(good));
    check("frame_bad_cnt", 32'(frame_bad_cnt), 32'(bad));
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst       = 1'b1;
    phy_rvalid_in = 1'b0;
    phy_rxd_in    = 8'h00;
    idle(3);
    check("reset tdata", 32'(m_axis_tdata), 32'h00);
    check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset tlast", 32'(m_axis_tlast), 32'd0);
    check("reset tuser", 32'(m_axis_tuser), 32'd0);
    sys_rst = 1'b0;
    idle(2);
    check_counts(0, 0);

    // Good 60-byte payload: 60 beats, last 0x3B clean.
    build_frame(60, 1'b0);
    expect_beats(60, 1'b0, 1'b1);
    send(7, 4);
    check_counts(1, 0);

    // FCS bit 0 flipped.
    do_reset();
    build_frame(60, 1'b1);
    expect_beats(60, 1'b1, 1'b1);
    send(7, 4);
    check_counts(0, 1);

    // 40-byte payload with valid FCS is a runt (44 < 64).
    do_reset();
    build_frame(40, 1'b0);
    expect_beats(40, 1'b1, 1'b1);
    send(7, 4);
    check_counts(0, 1);

    // Only 3 bytes after SFD: nothing reaches the hold register.
    do_reset();
    frame_q.delete();
    frame_q.push_back(8'hA0);
    frame_q.push_back(8'hA1);
    frame_q.push_back(8'hA2);
    send(7, 4);
    check_counts(0, 1);

    // Oversize: 1600 bytes, exactly MAX_FRAME-4 beats, last flagged bad.
    do_reset();
    frame_q.delete();
    for (int i = 0; i < 1600; i++) frame_q.push_back(8'(i));
    expect_beats(MAX_FRAME - 4, 1'b1, 1'b1);
    send(7, 4);
    check_counts(0, 1);

    // Bad preamble start lands in DROP, even a later SFD is ignored.
    do_reset();
    put(1'b1, 8'h55);
    put(1'b1, 8'h55);
    put(1'b1, 8'h12);
    put(1'b1, 8'hD5);
    put(1'b1, 8'h01);
    put(1'b1, 8'h02);
    idle(4);
    check_counts(0, 0);

    // Back-to-back good frames with a single-cycle rvalid gap.
    build_frame(60, 1'b0);
    expect_beats(60, 1'b0, 1'b1);
    send(7, 1);
    build_frame(70, 1'b0);
    expect_beats(70, 1'b0, 1'b1);
    send(7, 4);
    check_counts(2, 0);

    // Short preamble: SFD straight from IDLE.
    build_frame(60, 1'b0);
    expect_beats(60, 1'b0, 1'b1);
    send(0, 4);
    check_counts(3, 0);

    // Reset pulsed with payload byte 30: bytes 0..24 were already out.
    do_reset();
    build_frame(60, 1'b0);
    expect_beats(25, 1'b0, 1'b0);
    repeat (7) put(1'b1, 8'h55);
    put(1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) put(1'b1, frame_q[i]);
    sys_rst = 1'b1;
    put(1'b1, frame_q[30]);
    sys_rst = 1'b0;
    check("mid_reset tvalid", 32'(m_axis_tvalid), 32'd0);
    for (int i = 31; i < frame_q.size(); i++) put(1'b1, frame_q[i]);
    idle(4);
    check_counts(0, 0);
    build_frame(60, 1'b0);
    expect_beats(60, 1'b0, 1'b1);
    send(7, 4);
    check_counts(1, 0);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
